// File: rtl/serial_loader_piso.sv
// ---------------------------------------------------------------------------
// serial_loader_piso
//
// Parallel-in/serial-out loader feeding the serial input of a downstream
// shift register. It accepts a WIDTH-bit word through a valid/ready
// handshake and shifts it out MSB first, one bit per clock. A one-cycle
// `done` pulse marks the final bit of each frame. Back-to-back words
// stream with no idle gap.
//
// Optional feature (compile-time macro SERIALIZER_PARITY_EN):
//   when defined, an even-parity bit (XOR of all data bits) follows the
//   LSB, making the frame WIDTH+1 bits long.
//
// Parameters:
//   WIDTH       data word width, 2..32 (default 8)
//
// Ports:
//   clock       in   rising-edge clock
//   clear       in   synchronous active-high reset
//   load_valid  in   source presents a word on load_data
//   load_data   in   word to serialize, sampled only on accept
//   load_ready  out  loader can accept a word this cycle (combinational)
//   sout        out  registered serial bit
//   sout_valid  out  sout carries a data or parity bit this cycle
//   done        out  one-cycle pulse while the last bit is on sout
// ---------------------------------------------------------------------------
module serial_loader_piso #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

`ifdef SERIALIZER_PARITY_EN
    localparam int unsigned N = WIDTH + 1;
`else
    localparam int unsigned N = WIDTH;
`endif
    localparam int unsigned     CW   = $clog2(WIDTH + 2);
    localparam logic [CW-1:0]   LAST = CW'(N - 1);
`ifdef SERIALIZER_PARITY_EN
    localparam logic [CW-1:0]   PAR_IDX = CW'(WIDTH);
`endif

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             done_q, done_d;
`ifdef SERIALIZER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic last_bit;
    logic accept;

    always_comb begin
        last_bit   = (state_q == SHIFT) && (cnt_q == LAST);
        load_ready = (state_q == IDLE) || last_bit;
        accept     = load_valid && load_ready;

        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef SERIALIZER_PARITY_EN
        parity_d = parity_q;
`endif

        if (accept) begin
            state_d = SHIFT;
            shreg_d = load_data;
            cnt_d   = '0;
`ifdef SERIALIZER_PARITY_EN
            parity_d = ^load_data;
`endif
        end else if (state_q == SHIFT) begin
            if (last_bit) begin
                state_d = IDLE;
                shreg_d = '0;
                cnt_d   = '0;
            end else begin
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q + CW'(1);
            end
        end

        // Outputs are computed from the next state so they can be registered
        // and still line up with the bit that the next state represents.
        sout_valid_d = (state_d == SHIFT);
        done_d       = (state_d == SHIFT) && (cnt_d == LAST);
        sout_d       = (state_d == SHIFT) ? shreg_d[WIDTH-1] : 1'b0;
`ifdef SERIALIZER_PARITY_EN
        // The parity slot is never an accept cycle, so parity_q is current.
        if ((state_d == SHIFT) && (cnt_d == PAR_IDX)) begin
            sout_d = parity_q;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            done_q       <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            done_q       <= done_d;
`ifdef SERIALIZER_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign done       = done_q;

endmodule

// File: doc/serial_loader_piso.md
# serial_loader_piso

Parallel-in/serial-out loader that sits directly upstream of the 4-bit serial shift register and drives its serial input `A`. It accepts a WIDTH-bit word through a valid/ready handshake and presents it one bit per clock, MSB first, on `sout`. A one-cycle `done` pulse marks the final bit. Back-to-back words stream with no idle gap.

## Interface
Parameters:
- `WIDTH`, default 8: data word width; legal range 2..32.

Ports:
- `clock`  input  1: rising-edge clock, the only clock.
- `clear`  input  1: synchronous, active-high reset.
- `load_valid`  input  1: source presents a word on `load_data`.
- `load_data`  input  WIDTH: word to serialize; sampled only on an accept.
- `load_ready`  output  1: loader can accept a word this cycle.
- `sout`  output  1: serial bit, registered; drives the shift register's `A`.
- `sout_valid`  output  1: `sout` carries a data or parity bit this cycle.
- `done`  output  1: one-cycle pulse while the last bit of a word is on `sout`.

## Operation
- States: IDLE and SHIFT.
- Accept: `load_valid && load_ready` at a rising edge.
- `load_ready` is combinational:
  - 1 in IDLE.
  - 1 in SHIFT only during the last-bit cycle.
  - 0 otherwise.
- On accept:
  - Shift register loads `load_data`.
  - Bit counter resets to 0.
  - State becomes SHIFT.
  - `sout` becomes `load_data[WIDTH-1]` and `sout_valid` becomes 1.
- Each later edge in SHIFT:
  - Shift left one bit; `sout` takes the next lower bit.
  - Counter increments.
- Frame length N = WIDTH, or WIDTH+1 with parity (see Configuration).
- Last-bit cycle is counter == N-1; `done` is 1 in that cycle only.
- Edge after the last-bit cycle:
  - With an accept: load the new word as above and stay in SHIFT, with no gap.
  - Without an accept: go to IDLE; `sout`, `sout_valid` and `done` become 0.
- In IDLE, `sout` is 0.
- `load_data` and `load_valid` are ignored whenever `load_ready` is 0.
- Counter width is $clog2(WIDTH+2).
  - The counter never exceeds N-1.
  - It holds at 0 in IDLE.

## Timing
- Reset: `clear` high at an edge forces:
  - state IDLE, counter 0, shift register 0;
  - `sout`=0, `sout_valid`=0, `done`=0;
  - `load_ready`=1 from the following cycle.
- `clear` dominates a simultaneous accept; the word is dropped.
- `clear` mid-word aborts the word at once. No partial `done` is produced.
- Latency: for an accept at edge k, the MSB is on `sout` during cycle k..k+1, and bit i (MSB = 0) during cycle k+i.
- `done` is high during cycle k+N-1.
- Throughput: one word per N cycles when `load_valid` is held high.
- `sout` changes only on rising edges. It is glitch-free for a downstream stage sampling on the same edge.

## Configuration
- Macro: `SERIALIZER_PARITY_EN`.
- Defined:
  - N = WIDTH+1.
  - After the LSB, `sout` carries even parity: the XOR of all WIDTH data bits, captured at accept.
  - `done` is high with the parity bit.
  - `sout_valid` covers the parity bit.
- Undefined:
  - N = WIDTH.
  - No parity logic or storage is generated.
  - `done` is high with the LSB.

## Test plan
All scenarios use WIDTH=8.
- Single word: `clear` for 2 cycles, then accept 8'hA5 -> `sout` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles; `sout_valid` high exactly 8 cycles; `done` high only on the 8th; then `load_ready`=1 and `sout`=0.
- Back-to-back: hold `load_valid`=1 with 8'hFF, then 8'h00 on the second accept -> 16 contiguous `sout_valid` cycles, 8 ones then 8 zeros; `load_ready` high in cycle 8 only; two `done` pulses 8 cycles apart.
- Reset mid-word: accept 8'hF0, assert `clear` after 3 bits -> next cycle `sout`=0, `sout_valid`=0, no `done`, `load_ready`=1; then accept 8'h81 -> 1,0,0,0,0,0,0,1.
- Busy hold-off: raise `load_valid` with 8'h3C at bit 2 of word 8'hAA -> no accept until the last-bit cycle; 8'h3C follows with no gap and its bits are unaffected.
- Parity (`SERIALIZER_PARITY_EN`): accept 8'h07 -> 9 bits ending in 1, `done` on the 9th; accept 8'h03 -> 9th bit 0.
- Idle stability: `load_valid`=0 for 20 cycles after `clear` -> `sout`=0, `sout_valid`=0, `done`=0, `load_ready`=1 throughout.
